// File: rtl/regfile_pkg.sv
// Shared register-file types: widths, the writeback request record and requester ids.
package regfile_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } wb_req_t;

    typedef enum logic {
        REQ_EXEC = 1'b0,
        REQ_MEM  = 1'b1
    } req_id_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way writeback arbiter: round-robin on last_grant, or fixed load priority
// when REGFILE_WB_FIXED_PRIO_EN is defined. No grant is issued while reset is high.
module rr_arbiter2
    import regfile_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic i_req0,
    input  logic i_req1,
    output logic o_gnt0,
    output logic o_gnt1
);

`ifdef REGFILE_WB_FIXED_PRIO_EN
    // Load requester always wins; clk is only consumed to keep the port list uniform.
    logic w_unused_clk;
    assign w_unused_clk = clk;

    always_comb begin
        o_gnt0 = 1'b0;
        o_gnt1 = 1'b0;
        if (!reset) begin
            o_gnt1 = i_req1;
            o_gnt0 = i_req0 && !i_req1;
        end
    end
`else
    req_id_e r_last_grant;

    always_comb begin
        o_gnt0 = 1'b0;
        o_gnt1 = 1'b0;
        if (!reset) begin
            if (i_req0 && i_req1) begin
                // On contention the requester not served last goes first.
                o_gnt0 = (r_last_grant == REQ_MEM);
                o_gnt1 = (r_last_grant == REQ_EXEC);
            end else begin
                o_gnt0 = i_req0;
                o_gnt1 = i_req1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= REQ_MEM;
        end else if (o_gnt0) begin
            r_last_grant <= REQ_EXEC;
        end else if (o_gnt1) begin
            r_last_grant <= REQ_MEM;
        end
    end
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between execute and load writeback, with RAW
// hazard flags and a saturating contention counter. Option: REGFILE_WB_FIXED_PRIO_EN.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic              rs1_hazard,
    output logic              rs2_hazard,
    output logic [CNT_W-1:0]  contention_cnt
);

    // Handshake: a write transfers when reqN_valid && reqN_ready; ready is the
    // combinational grant, and the write stage never back-pressures.
    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_grant;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_data;

    logic              r_rd_en;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [DATA_W-1:0] r_rd_data;
    logic [CNT_W-1:0]  r_cnt;

    rr_arbiter2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .i_req0 (req0_valid),
        .i_req1 (req1_valid),
        .o_gnt0 (w_gnt0),
        .o_gnt1 (w_gnt1)
    );

    assign w_grant    = w_gnt0 || w_gnt1;
    assign w_sel_addr = w_gnt1 ? req1_addr : req0_addr;
    assign w_sel_data = w_gnt1 ? req1_data : req0_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
            r_rd_data <= '0;
            r_cnt     <= '0;
        end else begin
            // x0 writes are accepted but never enable the register file.
            r_rd_en <= w_grant && (w_sel_addr != '0);
            if (w_grant) begin
                r_rd_addr <= w_sel_addr;
                r_rd_data <= w_sel_data;
            end
            if (req0_valid && req1_valid && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign req0_ready     = w_gnt0;
    assign req1_ready     = w_gnt1;
    assign rd_en          = r_rd_en;
    assign rd_addr        = r_rd_addr;
    assign rd_data        = r_rd_data;
    assign contention_cnt = r_cnt;

    assign rs1_hazard = r_rd_en && (r_rd_addr == rs1_addr) && (rs1_addr != '0);
    assign rs2_hazard = r_rd_en && (r_rd_addr == rs2_addr) && (rs2_addr != '0);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: per-cycle vector table plus contention
// saturation and reset-mid-operation sequences.
module tb_regfile_wb_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              reset;
    logic              req0_valid, req1_valid;
    logic [ADDR_W-1:0] req0_addr, req1_addr;
    logic [DATA_W-1:0] req0_data, req1_data;
    logic              req0_ready, req1_ready;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] rs1_addr, rs2_addr;
    logic              rs1_hazard, rs2_hazard;
    logic [CNT_W-1:0]  contention_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .req0_valid     (req0_valid),
        .req0_addr      (req0_addr),
        .req0_data      (req0_data),
        .req0_ready     (req0_ready),
        .req1_valid     (req1_valid),
        .req1_addr      (req1_addr),
        .req1_data      (req1_data),
        .req1_ready     (req1_ready),
        .rd_en          (rd_en),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .rs1_addr       (rs1_addr),
        .rs2_addr       (rs2_addr),
        .rs1_hazard     (rs1_hazard),
        .rs2_hazard     (rs2_hazard),
        .contention_cnt (contention_cnt)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One row = inputs for a cycle and the outputs expected in that same cycle
    // (registered outputs reflect the edges of earlier rows).
    typedef struct {
        logic        rst;
        logic        v0;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic        v1;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        r0;
        logic        r1;
        logic        en;
        logic [4:0]  ra;
        logic [31:0] rdat;
        logic        h1;
        logic        h2;
        logic [3:0]  cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic rst, input logic v0, input logic [4:0] a0, input logic [31:0] d0,
        input logic v1, input logic [4:0] a1, input logic [31:0] d1,
        input logic [4:0] rs1, input logic [4:0] rs2,
        input logic r0, input logic r1, input logic en, input logic [4:0] ra,
        input logic [31:0] rdat, input logic h1, input logic h2, input logic [3:0] cnt);
        vec_t v;
        v.rst = rst; v.v0 = v0; v.a0 = a0; v.d0 = d0;
        v.v1 = v1; v.a1 = a1; v.d1 = d1; v.rs1 = rs1; v.rs2 = rs2;
        v.r0 = r0; v.r1 = r1; v.en = en; v.ra = ra; v.rdat = rdat;
        v.h1 = h1; v.h2 = h2; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Driver: drive on the falling edge, sample 1 time unit later.
    task automatic drive(input logic rst, input logic v0, input logic [4:0] a0,
                         input logic [31:0] d0, input logic v1, input logic [4:0] a1,
                         input logic [31:0] d1, input logic [4:0] rs1, input logic [4:0] rs2);
        @(negedge clk);
        reset = rst;
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        rs1_addr = rs1; rs2_addr = rs2;
        #1;
    endtask

    task automatic apply_check(input int idx, input vec_t v);
        string tag;
        drive(v.rst, v.v0, v.a0, v.d0, v.v1, v.a1, v.d1, v.rs1, v.rs2);
        tag = $sformatf("row%0d", idx);
        chk({tag, ".req0_ready"}, {31'd0, req0_ready}, {31'd0, v.r0});
        chk({tag, ".req1_ready"}, {31'd0, req1_ready}, {31'd0, v.r1});
        chk({tag, ".rd_en"}, {31'd0, rd_en}, {31'd0, v.en});
        chk({tag, ".rd_addr"}, {27'd0, rd_addr}, {27'd0, v.ra});
        chk({tag, ".rd_data"}, rd_data, v.rdat);
        chk({tag, ".rs1_hazard"}, {31'd0, rs1_hazard}, {31'd0, v.h1});
        chk({tag, ".rs2_hazard"}, {31'd0, rs2_hazard}, {31'd0, v.h2});
        chk({tag, ".contention_cnt"}, {28'd0, contention_cnt}, {28'd0, v.cnt});
    endtask

    initial begin
        logic [3:0] exp_cnt;
        int         sat_cycles;

        reset = 1'b1;
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
        rs1_addr = '0; rs2_addr = '0;
        @(posedge clk);

        //           rst v0 a0 d0            v1 a1 d1        rs1 rs2  r0 r1 en ra rdat          h1 h2 cnt
        vecs.push_back(mk(1, 1, 3, 32'h33,   0, 0, 0,        0, 0,    0, 0, 0, 0, 32'h0,        0, 0, 0));
        vecs.push_back(mk(0, 1, 5, 32'hDEADBEEF, 0, 0, 0,    5, 0,    1, 0, 0, 0, 32'h0,        0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,        0, 0, 0,        5, 5,    0, 0, 1, 5, 32'hDEADBEEF, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0,        0, 0, 0,        5, 0,    0, 0, 0, 5, 32'hDEADBEEF, 0, 0, 0));
`ifdef REGFILE_WB_FIXED_PRIO_EN
        vecs.push_back(mk(0, 1, 1, 32'h11,   1, 2, 32'h22,   0, 0,    0, 1, 0, 0, 32'h0,        0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 32'h11,   1, 2, 32'h22,   0, 0,    0, 1, 1, 2, 32'h22,       0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 32'h11,   1, 2, 32'h22,   0, 0,    0, 1, 1, 2, 32'h22,       0, 0, 2));
        vecs.push_back(mk(0, 1, 1, 32'h11,   1, 2, 32'h22,   0, 0,    0, 1, 1, 2, 32'h22,       0, 0, 3));
`else
        vecs.push_back(mk(0, 1, 1, 32'h11,   1, 2, 32'h22,   0, 0,    1, 0, 0, 0, 32'h0,        0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 32'h11,   1, 2, 32'h22,   0, 0,    0, 1, 1, 1, 32'h11,       0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 32'h11,   1, 2, 32'h22,   0, 0,    1, 0, 1, 2, 32'h22,       0, 0, 2));
        vecs.push_back(mk(0, 1, 1, 32'h11,   1, 2, 32'h22,   0, 0,    0, 1, 1, 1, 32'h11,       0, 0, 3));
`endif
        vecs.push_back(mk(0, 0, 0, 0,        1, 0, 32'h1234, 0, 0,    0, 1, 1, 2, 32'h22,       0, 0, 4));
        vecs.push_back(mk(0, 1, 7, 32'h77,   0, 0, 0,        0, 0,    1, 0, 0, 0, 32'h1234,     0, 0, 4));
        vecs.push_back(mk(0, 0, 0, 0,        0, 0, 0,        7, 8,    0, 0, 1, 7, 32'h77,       1, 0, 4));
        vecs.push_back(mk(0, 0, 0, 0,        0, 0, 0,        7, 8,    0, 0, 0, 7, 32'h77,       0, 0, 4));

        foreach (vecs[i]) apply_check(i, vecs[i]);

        // Continuous contention for 20 cycles: exactly one grant per cycle and
        // the counter climbs from 4 and sticks at 0xF.
        exp_cnt = 4'd4;
        sat_cycles = 20;
        for (int c = 0; c < sat_cycles; c++) begin
            drive(0, 1, 9, 32'hA0 + c, 1, 10, 32'hB0 + c, 0, 0);
            chk($sformatf("sat%0d.one_grant", c), {31'd0, req0_ready ^ req1_ready}, 32'd1);
            chk($sformatf("sat%0d.cnt", c), {28'd0, contention_cnt}, {28'd0, exp_cnt});
            if (exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("sat.final_cnt", {28'd0, contention_cnt}, 32'hF);

        // Reset arriving while a write is being offered: no ready, state cleared.
        drive(0, 1, 4, 32'h44, 0, 0, 0, 0, 0);
        chk("mid.pre_ready0", {31'd0, req0_ready}, 32'd1);
        drive(1, 1, 3, 32'h33, 0, 0, 0, 0, 0);
        chk("mid.rst_ready0", {31'd0, req0_ready}, 32'd0);
        chk("mid.rst_en_before", {31'd0, rd_en}, 32'd1);
        drive(0, 0, 0, 0, 0, 0, 0, 3, 0);
        chk("mid.rd_en", {31'd0, rd_en}, 32'd0);
        chk("mid.rd_data", rd_data, 32'd0);
        chk("mid.rd_addr", {27'd0, rd_addr}, 32'd0);
        chk("mid.cnt", {28'd0, contention_cnt}, 32'd0);
        chk("mid.rs1_hazard", {31'd0, rs1_hazard}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
